// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stage_sequencer
// Purpose  : Multi-cycle stage sequencer. Pulses the enable of each stage in
//            turn, owns the PC, handles branch/trap/mret redirects, counts
//            retired instructions and halts at instruction boundaries.
// Revision : 1.0
// ============================================================================
module stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_start,
  input  logic        i_halt_req,
  output logic        o_fetch_en,
  output logic        o_decode_en,
  output logic        o_exec_en,
  output logic        o_mem_en,
  output logic        o_wb_en,
  input  logic        i_fetch_done,
  input  logic        i_decode_done,
  input  logic        i_exec_done,
  input  logic        i_mem_done,
  input  logic        i_wb_done,
  input  logic        i_is_mem,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_trap,
  input  logic [31:0] i_trap_cause,
  input  logic        i_mret,
  input  logic [31:0] i_mtvec,
  output logic [31:0] o_pc,
  output logic [31:0] o_mepc,
  output logic [31:0] o_mcause,
  output logic [31:0] o_instret,
  output logic        o_busy,
  output logic        o_halted
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_F_ISS  = 4'd1;
  localparam logic [3:0] S_F_WAIT = 4'd2;
  localparam logic [3:0] S_D_ISS  = 4'd3;
  localparam logic [3:0] S_D_WAIT = 4'd4;
  localparam logic [3:0] S_E_ISS  = 4'd5;
  localparam logic [3:0] S_E_WAIT = 4'd6;
  localparam logic [3:0] S_M_ISS  = 4'd7;
  localparam logic [3:0] S_M_WAIT = 4'd8;
  localparam logic [3:0] S_W_ISS  = 4'd9;
  localparam logic [3:0] S_W_WAIT = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  logic [3:0]  r_state;
  logic [3:0]  w_state_nxt;
  logic [4:0]  w_en_nxt;
  logic        w_busy_nxt;
  logic        w_halted_nxt;
  logic [4:0]  r_en;
  logic        r_busy;
  logic        r_halted;
  logic        r_is_mem;
  logic [31:0] r_npc;
  logic [31:0] r_trap_cause;
  logic [31:0] r_pc;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_instret;
  logic        w_d_exit;
  logic        w_e_exit;
  logic        w_w_exit;

  assign w_d_exit = (r_state == S_D_WAIT) && i_decode_done;
  assign w_e_exit = (r_state == S_E_WAIT) && i_exec_done;
  assign w_w_exit = (r_state == S_W_WAIT) && i_wb_done;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (i_start) w_state_nxt = S_F_ISS;
      S_F_ISS:  w_state_nxt = S_F_WAIT;
      S_F_WAIT: if (i_fetch_done) w_state_nxt = S_D_ISS;
      S_D_ISS:  w_state_nxt = S_D_WAIT;
      S_D_WAIT: if (i_decode_done) w_state_nxt = S_E_ISS;
      S_E_ISS:  w_state_nxt = S_E_WAIT;
      S_E_WAIT: begin
        if (i_exec_done) begin
          if (i_trap)        w_state_nxt = S_TRAP;
          else if (r_is_mem) w_state_nxt = S_M_ISS;
          else               w_state_nxt = S_W_ISS;
        end
      end
      S_M_ISS:  w_state_nxt = S_M_WAIT;
      S_M_WAIT: if (i_mem_done) w_state_nxt = S_W_ISS;
      S_W_ISS:  w_state_nxt = S_W_WAIT;
      S_W_WAIT: if (i_wb_done) w_state_nxt = i_halt_req ? S_HALT : S_F_ISS;
      S_TRAP:   w_state_nxt = i_halt_req ? S_HALT : S_F_ISS;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    w_en_nxt = 5'b00000;
    case (w_state_nxt)
      S_F_ISS: w_en_nxt[0] = 1'b1;
      S_D_ISS: w_en_nxt[1] = 1'b1;
      S_E_ISS: w_en_nxt[2] = 1'b1;
      S_M_ISS: w_en_nxt[3] = 1'b1;
      S_W_ISS: w_en_nxt[4] = 1'b1;
      default: w_en_nxt = 5'b00000;
    endcase
    w_busy_nxt   = (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALT);
    w_halted_nxt = (w_state_nxt == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_en     <= 5'b00000;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_en     <= w_en_nxt;
      r_busy   <= w_busy_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // The redirect target is resolved at execute exit; mepc cannot change
  // between then and writeback, so mret may use it early.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_is_mem     <= 1'b0;
      r_npc        <= 32'd0;
      r_trap_cause <= 32'd0;
      r_pc         <= RESET_PC;
      r_mepc       <= 32'd0;
      r_mcause     <= 32'd0;
      r_instret    <= 32'd0;
    end else begin
      if (w_d_exit) r_is_mem <= i_is_mem;
      if (w_e_exit) begin
        if (i_trap)              r_trap_cause <= i_trap_cause;
        else if (i_mret)         r_npc <= r_mepc;
        else if (i_branch_taken) r_npc <= i_branch_target;
        else                     r_npc <= r_pc + 32'd1;
      end
      if (w_w_exit) begin
        r_pc      <= r_npc;
        r_instret <= r_instret + 32'd1;
      end
      if (r_state == S_TRAP) begin
        r_mepc   <= r_pc;
        r_mcause <= r_trap_cause;
        r_pc     <= i_mtvec;
      end
    end
  end

  assign o_fetch_en  = r_en[0];
  assign o_decode_en = r_en[1];
  assign o_exec_en   = r_en[2];
  assign o_mem_en    = r_en[3];
  assign o_wb_en     = r_en[4];
  assign o_busy      = r_busy;
  assign o_halted    = r_halted;
  assign o_pc        = r_pc;
  assign o_mepc      = r_mepc;
  assign o_mcause    = r_mcause;
  assign o_instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_sequencer
// Purpose  : Directed bench for stage_sequencer with an instruction-level
//            reference model checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_stage_sequencer;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clk = 1'b0;
  logic        rstn, start, halt_req;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic [4:0]  dn;
  logic        is_mem, branch_taken, trap, mret;
  logic [31:0] branch_target, trap_cause, mtvec;
  logic [31:0] pc, mepc, mcause, instret;
  logic        busy, halted;
  logic [4:0]  w_en;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  stage_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn), .i_start(start), .i_halt_req(halt_req),
    .o_fetch_en(fetch_en), .o_decode_en(decode_en), .o_exec_en(exec_en),
    .o_mem_en(mem_en), .o_wb_en(wb_en),
    .i_fetch_done(dn[0]), .i_decode_done(dn[1]), .i_exec_done(dn[2]),
    .i_mem_done(dn[3]), .i_wb_done(dn[4]),
    .i_is_mem(is_mem), .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .i_trap(trap), .i_trap_cause(trap_cause), .i_mret(mret), .i_mtvec(mtvec),
    .o_pc(pc), .o_mepc(mepc), .o_mcause(mcause), .o_instret(instret),
    .o_busy(busy), .o_halted(halted)
  );

  assign w_en = {wb_en, mem_en, exec_en, decode_en, fetch_en};

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stage responders: each stage answers lat[s] cycles after its enable.
  int lat [5];
  int pend[5];
  initial begin
    dn = 5'b0;
    for (int s = 0; s < 5; s++) begin lat[s] = 1; pend[s] = 0; end
    forever begin
      @(negedge clk);
      for (int s = 0; s < 5; s++) begin
        dn[s] = 1'b0;
        if (pend[s] > 0) begin
          pend[s]--;
          if (pend[s] == 0) dn[s] = 1'b1;
        end
        if (w_en[s]) pend[s] = lat[s];
      end
    end
  end

  // Reference model: an instruction is a queue of remaining steps
  // (0 F, 1 D, 2 E, 3 M, 4 W, 5 TRAP); each step ends on its done input.
  int          m_q[$];
  bit          m_act = 1'b0, m_halt = 1'b0, m_fresh = 1'b0, m_ismem = 1'b0;
  logic [4:0]  m_en = 5'b0;
  logic [31:0] m_pc = RESET_PC, m_mepc = 0, m_mcause = 0, m_instret = 0;
  logic [31:0] m_npc = 0, m_cause = 0;

  task automatic m_new();
    m_q.delete();
    m_q.push_back(0); m_q.push_back(1); m_q.push_back(2);
    m_en[0] = 1'b1;
    m_fresh = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    m_en = 5'b0;
    if (!rstn) begin
      m_q.delete();
      m_act = 0; m_halt = 0; m_fresh = 0;
      m_pc = RESET_PC; m_mepc = 0; m_mcause = 0; m_instret = 0;
    end else if (!m_act) begin
      if (start) begin m_act = 1; m_halt = 0; m_new(); end
    end else if (m_fresh) begin
      m_fresh = 0;
    end else begin
      if (m_q[0] == 5) begin
        m_mepc = m_pc; m_mcause = m_cause; m_pc = mtvec;
        void'(m_q.pop_front());
      end else if (dn[m_q[0]]) begin
        case (m_q[0])
          1: m_ismem = is_mem;
          2: begin
            if (trap) begin
              m_cause = trap_cause;
              m_q.push_back(5);
            end else begin
              m_npc = mret ? m_mepc : (branch_taken ? branch_target : m_pc + 1);
              if (m_ismem) m_q.push_back(3);
              m_q.push_back(4);
            end
          end
          4: begin m_pc = m_npc; m_instret = m_instret + 1; end
          default: ;
        endcase
        void'(m_q.pop_front());
        if (m_q.size() != 0 && m_q[0] != 5) begin
          m_en[m_q[0]] = 1'b1;
          m_fresh = 1'b1;
        end
      end
      if (m_q.size() == 0) begin
        if (halt_req) begin m_act = 0; m_halt = 1; end
        else m_new();
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("enables", {27'd0, w_en}, {27'd0, m_en});
      chk("pc", pc, m_pc);
      chk("mepc", mepc, m_mepc);
      chk("mcause", mcause, m_mcause);
      chk("instret", instret, m_instret);
      chk("busy", {31'd0, busy}, {31'd0, m_act});
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
    end
  end

  int ri_span, ri_nf, ri_nm, ri_nw;
  bit ri_halt;

  // Called at the negedge where this instruction's fetch_en is seen; returns
  // at the next fetch_en or on halt.
  task automatic run_instr(input logic mem, input logic br, input logic [31:0] tgt,
                           input logic tr, input logic [31:0] cause, input logic mr,
                           input logic hr);
    bit raise = 1'b0;
    is_mem = mem; branch_taken = br; branch_target = tgt;
    trap = tr; trap_cause = cause; mret = mr;
    ri_span = 0; ri_halt = 0; ri_nf = 0; ri_nm = 0; ri_nw = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (raise) begin halt_req = 1'b1; raise = 1'b0; end
      if (hr && exec_en) raise = 1'b1;
      if (mem_en) ri_nm++;
      if (wb_en) ri_nw++;
      if (fetch_en) begin ri_span = i; return; end
      if (halted) begin ri_span = i; ri_halt = 1; return; end
    end
    n_checks++; n_errors++;
    $display("FAIL instr_timeout: got no fetch_en/halted within 80 cycles");
  endtask

  int t0, tf, acc_m;
  bit seen;

  initial begin
    rstn = 0; start = 0; halt_req = 0;
    is_mem = 0; branch_taken = 0; branch_target = 0;
    trap = 0; trap_cause = 0; mret = 0; mtvec = 32'd47;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instret", instret, 32'd0);
    chk("rst_busy_halted", {30'd0, busy, halted}, 32'd0);
    rstn = 1;

    // Sequential: three non-mem instructions
    @(negedge clk); start = 1; t0 = cyc;
    @(negedge clk); start = 0;
    chk("f1_en", {31'd0, fetch_en}, 32'd1);
    chk("f1_cycle", cyc - t0, 32'd1);
    chk("f1_pc", pc, 32'd0);
    acc_m = 0;
    run_instr(0, 0, 0, 0, 0, 0, 0); acc_m += ri_nm;
    chk("f2_cycle", cyc - t0, 32'd9);
    chk("f2_pc", pc, 32'd1);
    run_instr(0, 0, 0, 0, 0, 0, 0); acc_m += ri_nm;
    chk("f3_cycle", cyc - t0, 32'd17);
    chk("f3_pc", pc, 32'd2);
    run_instr(0, 0, 0, 0, 0, 0, 0); acc_m += ri_nm;
    chk("seq_instret", instret, 32'd3);
    chk("seq_no_mem", acc_m, 32'd0);

    // Mem + branch to 0x23, then branch to 8
    run_instr(1, 1, 32'h23, 0, 0, 0, 0);
    chk("mem_span", ri_span, 32'd10);
    chk("mem_pulses", ri_nm, 32'd1);
    chk("br_pc", pc, 32'h23);
    run_instr(0, 1, 32'd8, 0, 0, 0, 0);
    chk("br2_pc", pc, 32'd8);

    // Trap at pc 8, then mret
    run_instr(0, 0, 0, 1, 32'd11, 0, 0);
    chk("trap_span", ri_span, 32'd7);
    chk("trap_no_mem_wb", ri_nm + ri_nw, 32'd0);
    chk("trap_mepc", mepc, 32'd8);
    chk("trap_mcause", mcause, 32'd11);
    chk("trap_pc", pc, 32'd47);
    chk("trap_instret", instret, 32'd5);
    run_instr(0, 0, 0, 0, 0, 1, 0);
    chk("mret_pc", pc, 32'd8);
    chk("mret_instret", instret, 32'd6);

    // Trap and taken branch together: trap wins
    run_instr(0, 1, 32'h99, 1, 32'd3, 0, 0);
    chk("trapbr_pc", pc, 32'd47);
    chk("trapbr_mcause", mcause, 32'd3);

    // Halt requested during execute
    run_instr(0, 0, 0, 0, 0, 0, 1);
    chk("halt_hit", {31'd0, ri_halt}, 32'd1);
    chk("halt_span", ri_span, 32'd8);
    chk("halt_pc", pc, 32'd48);
    chk("halt_instret", instret, 32'd7);
    halt_req = 0;
    repeat (3) @(negedge clk);
    chk("still_halted", {31'd0, halted}, 32'd1);

    // Resume with fetch stalled 5 cycles; a stray start while busy is ignored
    lat[0] = 6;
    start = 1;
    @(negedge clk);
    chk("resume_fetch", {31'd0, fetch_en}, 32'd1);
    chk("resume_pc", pc, 32'd48);
    @(negedge clk); start = 0; lat[0] = 1;
    run_instr(0, 0, 0, 0, 0, 0, 0);
    chk("stall_span", ri_span, 32'd12);
    chk("stall_no_dup_fetch", ri_nf, 32'd0);
    chk("stall_pc", pc, 32'd49);

    // Reset during M_WAIT
    is_mem = 1; lat[3] = 4;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_en) seen = 1;
    end
    chk("reach_mem", {31'd0, seen}, 32'd1);
    @(negedge clk); rstn = 0;
    @(negedge clk);
    chk("rmid_en", {27'd0, w_en}, 32'd0);
    chk("rmid_pc", pc, RESET_PC);
    chk("rmid_instret", instret, 32'd0);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    rstn = 1; lat[3] = 1; is_mem = 0;
    repeat (5) @(negedge clk);

    // Restart after reset
    start = 1; tf = cyc;
    @(negedge clk); start = 0;
    chk("restart_fetch", {31'd0, fetch_en}, 32'd1);
    chk("restart_cycle", cyc - tf, 32'd1);
    run_instr(0, 0, 0, 0, 0, 0, 0);
    chk("restart_pc", pc, 32'd1);
    chk("restart_instret", instret, 32'd1);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control FSM for the core. It issues one-cycle enable pulses to the fetch, decode, execute, memory and writeback stages in order, and waits for each stage's `completed` level before moving on. It owns the architectural PC, handles branch, trap (ecall/ebreak) and mret redirects, counts retired instructions, and supports halting at instruction boundaries. It sits above all stage modules; the `pc` it drives is the word index used by fetch.

## Interface
- `RESET_PC`, default 0: word-index PC loaded at reset.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: leaves IDLE or HALT and begins fetching.
- `halt_req` in 1: level; halt at the next instruction boundary.
- `fetch_en`, `decode_en`, `exec_en`, `mem_en`, `wb_en` out 1 each: one-cycle stage enable pulses.
- `fetch_done`, `decode_done`, `exec_done`, `mem_done`, `wb_done` in 1 each: stage `completed` levels.
- `is_mem` in 1: from decode, sampled at `decode_done`; instruction needs the MEM stage.
- `branch_taken` in 1: from execute, sampled at `exec_done`.
- `branch_target` in 32: from execute, sampled at `exec_done`.
- `trap` in 1: from execute, sampled at `exec_done`; ecall/ebreak raised.
- `trap_cause` in 32: from execute, sampled at `exec_done`.
- `mret` in 1: from execute, sampled at `exec_done`.
- `mtvec` in 32: trap vector, word index.
- `pc` out 32: current instruction word index.
- `mepc` out 32: saved PC of the trapping instruction.
- `mcause` out 32: latched trap cause.
- `instret` out 32: count of retired instructions.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in the HALT state.

## Operation
- States: IDLE, F_ISS, F_WAIT, D_ISS, D_WAIT, E_ISS, E_WAIT, M_ISS, M_WAIT, W_ISS, W_WAIT, TRAP, HALT.
- An X_ISS state drives X_en=1 for exactly one cycle, then goes to X_WAIT.
- X_WAIT holds until X_done=1, then goes to the next ISS state.
- A done input seen while its own en is high, or outside its WAIT state, is ignored.
- IDLE: on `start`, go to F_ISS.
- D_WAIT exit: latch `is_mem`.
- E_WAIT exit, priority order:
  - `trap`: go to TRAP. MEM and WB are skipped; the instruction does not retire.
  - Otherwise, latch the redirect source. Priority is mret > branch_taken > sequential. Then go to M_ISS if the latched `is_mem` is set, else W_ISS.
- W_WAIT exit:
  - Update `pc`: `mepc` for mret, `branch_target` for a taken branch, otherwise `pc`+1 (32-bit wrap).
  - Increment `instret` (wraps from 0xFFFFFFFF to 0).
  - If `halt_req`, go to HALT; otherwise go to F_ISS.
- TRAP (one cycle): `mepc`<=`pc`, `mcause`<=latched `trap_cause`, `pc`<=`mtvec`. If `halt_req`, go to HALT, else F_ISS.
- HALT: on `start`, go to F_ISS with `pc` unchanged.
- `halt_req` is never honored mid-instruction.

## Timing
- Reset (rstn=0 at an edge) sets:
  - state IDLE, all `*_en`=0, `busy`=0, `halted`=0;
  - `pc`=RESET_PC, `mepc`=0, `mcause`=0, `instret`=0.
- Reset mid-instruction aborts it: no PC update, no retire. Stage enables are low from the next cycle.
- All outputs are registered.
- Stage handshake: en high in cycle N. If done is first high in cycle M (M ≥ N+1), the next stage's en is high in cycle M+1.
- With every stage answering in the cycle after its en:
  - non-mem instruction: 8 cycles from `fetch_en` to the next `fetch_en`;
  - mem instruction: 10 cycles;
  - trap: 7 cycles (F, D, E, TRAP).
- `pc` changes only in the cycle after the W_WAIT exit or TRAP; it is stable throughout fetch of an instruction.
- `start` is ignored while `busy`.

## Test plan
- Sequential: RESET_PC=0, three non-mem instructions, each stage done one cycle after en.
  - `fetch_en` at cycles 1, 9, 17.
  - `pc` reads 0, 1, 2.
  - `instret`=3.
  - `mem_en` never asserted.
- Mem and branch: `is_mem`=1 and `branch_taken`=1 with `branch_target`=0x23 on the first instruction.
  - `mem_en` pulses once.
  - Next `pc`=0x23.
  - 10-cycle spacing between fetch enables.
- Trap: `trap`=1 and `trap_cause`=11 at pc=8, `mtvec`=47.
  - No `mem_en` or `wb_en`.
  - `mepc`=8, `mcause`=11, `pc`=47.
  - `instret` unchanged.
  - Then an mret instruction gives `pc`=8.
- Trap and branch together: `trap`=1 and `branch_taken`=1 at the same `exec_done`. Trap wins; `pc`=`mtvec`.
- Halt and stall:
  - `halt_req` raised during E_WAIT: `halted`=1 only after `wb_done`, with `pc` advanced.
  - `start` resumes from that `pc`.
  - `fetch_done` held low for 5 cycles: `decode_en` waits, with no duplicate `fetch_en`.
- Reset mid-op: rstn=0 during M_WAIT.
  - Next cycle: all enables 0, `pc`=RESET_PC, `instret`=0, state IDLE.
